// File: rtl/main_memoria.sv
// Point recorder/player: records up to 16 {x,y} points, then plays them back on request.
// Optional macro MAIN_MEMORIA_SYNC_EN adds a 2-flop synchronizer on all control inputs.
module main_memoria (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar_detener,
    input  logic       pausar_reaundar,
    input  logic       cancelar,
    input  logic       cortar,
    input  logic [5:0] x_sensor,
    input  logic [5:0] y_sensor,
    input  logic       guardar_xy,
    input  logic       dato_siguiente,
    output logic [5:0] x_salida,
    output logic [5:0] y_salida,
    output logic       cortando,
    output logic [3:0] estado_actual
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RECORD = 4'd1,
        CUT    = 4'd2,
        PAUSE  = 4'd3,
        DONE   = 4'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [5:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic        cortando_q, cortando_d;
    logic        wr_en;
    logic [11:0] mem_q [16];

    logic [5:0]  ctrl_in;
    logic [5:0]  ctrl_s;
    logic [5:0]  prev_q;
    logic [5:0]  edges;
    logic        ev_cancel, ev_start, ev_pause, ev_cut, ev_save, ev_next;

    // Bit order doubles as priority order: highest bit wins.
    assign ctrl_in = {cancelar, iniciar_detener, pausar_reaundar, cortar, guardar_xy, dato_siguiente};

`ifdef MAIN_MEMORIA_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ctrl_in;
            sync2_q <= sync1_q;
        end
    end

    assign ctrl_s = sync2_q;
`else
    assign ctrl_s = ctrl_in;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= ctrl_s;
        end
    end

    assign edges = ctrl_s & ~prev_q;

    always_comb begin
        ev_cancel = 1'b0;
        ev_start  = 1'b0;
        ev_pause  = 1'b0;
        ev_cut    = 1'b0;
        ev_save   = 1'b0;
        ev_next   = 1'b0;
        if (edges[5]) begin
            ev_cancel = 1'b1;
        end else if (edges[4]) begin
            ev_start = 1'b1;
        end else if (edges[3]) begin
            ev_pause = 1'b1;
        end else if (edges[2]) begin
            ev_cut = 1'b1;
        end else begin
            ev_save = edges[1];
            ev_next = edges[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_en      = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        cortando_d = 1'b0;

        if (ev_cancel) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_start) begin
                        state_d  = RECORD;
                        count_d  = '0;
                        wr_ptr_d = '0;
                    end
                end
                RECORD: begin
                    if (ev_start) begin
                        state_d = IDLE;
                    end else if (ev_cut) begin
                        if (count_q != 5'd0) begin
                            state_d  = CUT;
                            rd_ptr_d = '0;
                        end
                    end else if (ev_save && (count_q < 5'd16)) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        count_d  = count_q + 5'd1;
                    end
                end
                CUT: begin
                    if (ev_start) begin
                        state_d = IDLE;
                    end else if (ev_pause) begin
                        state_d = PAUSE;
                    end else if (ev_next) begin
                        if (({1'b0, rd_ptr_q} + 5'd1) < count_q) begin
                            rd_ptr_d = rd_ptr_q + 4'd1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (ev_start) begin
                        state_d = IDLE;
                    end else if (ev_pause) begin
                        state_d = CUT;
                    end
                end
                DONE: begin
                    if (ev_start) begin
                        state_d = IDLE;
                    end else if (ev_cut) begin
                        state_d  = CUT;
                        rd_ptr_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the state being entered so they appear right after the edge.
        case (state_d)
            IDLE, RECORD: begin
                x_d = '0;
                y_d = '0;
            end
            CUT: begin
                {x_d, y_d} = mem_q[rd_ptr_d];
                cortando_d = 1'b1;
            end
            default: begin
                x_d = x_q;
                y_d = y_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cortando_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cortando_q <= cortando_d;
        end
    end

    // Point storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {x_sensor, y_sensor};
        end
    end

    assign x_salida      = x_q;
    assign y_salida      = y_q;
    assign cortando      = cortando_q;
    assign estado_actual = state_q;

endmodule

// File: tb/tb_main_memoria.sv
// Testbench for main_memoria: behavioural point-list model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_main_memoria;

    localparam logic [5:0] CAN = 6'b100000;
    localparam logic [5:0] INI = 6'b010000;
    localparam logic [5:0] PAU = 6'b001000;
    localparam logic [5:0] COR = 6'b000100;
    localparam logic [5:0] GUA = 6'b000010;
    localparam logic [5:0] DAT = 6'b000001;

    logic       clock;
    logic       reset_n;
    logic [5:0] ctrl;
    logic [5:0] x_sensor, y_sensor;
    logic [5:0] x_salida, y_salida;
    logic       cortando;
    logic [3:0] estado_actual;

    int n_compared = 0;
    int n_failed   = 0;

    main_memoria dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .iniciar_detener (ctrl[4]),
        .pausar_reaundar (ctrl[3]),
        .cancelar        (ctrl[5]),
        .cortar          (ctrl[2]),
        .x_sensor        (x_sensor),
        .y_sensor        (y_sensor),
        .guardar_xy      (ctrl[1]),
        .dato_siguiente  (ctrl[0]),
        .x_salida        (x_salida),
        .y_salida        (y_salida),
        .cortando        (cortando),
        .estado_actual   (estado_actual)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a list of recorded points, a playback index and a mode number.
    int         m_state;
    int         m_count;
    int         m_rd;
    logic [11:0] m_points [16];
    logic [5:0] m_x, m_y;
    logic [5:0] m_prev;
    bit         m_valid = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        logic [5:0] e;
        if (!reset_n) begin
            m_state = 0; m_count = 0; m_rd = 0;
            m_x = 0; m_y = 0; m_prev = 0; m_valid = 1'b1;
        end else begin
            e = ctrl & ~m_prev;
            m_prev = ctrl;
            if (e[5]) begin
                m_state = 0; m_count = 0; m_rd = 0;
            end else if (e[4]) begin
                if (m_state == 0) begin
                    m_state = 1; m_count = 0;
                end else begin
                    m_state = 0;
                end
            end else if (e[3]) begin
                if (m_state == 2) m_state = 3;
                else if (m_state == 3) m_state = 2;
            end else if (e[2]) begin
                if ((m_state == 1 && m_count > 0) || m_state == 4) begin
                    m_state = 2; m_rd = 0;
                end
            end else begin
                if (e[1] && m_state == 1 && m_count < 16) begin
                    m_points[m_count] = {x_sensor, y_sensor};
                    m_count++;
                end
                if (e[0] && m_state == 2) begin
                    if (m_rd < m_count - 1) m_rd++;
                    else m_state = 4;
                end
            end
            if (m_state == 0 || m_state == 1) begin
                m_x = 0; m_y = 0;
            end else if (m_state == 2) begin
                m_x = m_points[m_rd][11:6];
                m_y = m_points[m_rd][5:0];
            end
        end
    end

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid && reset_n) begin
            check_output("model estado", 12'(estado_actual), 12'(m_state));
            check_output("model cortando", 12'(cortando), 12'(m_state == 2));
            check_output("model x", 12'(x_salida), 12'(m_x));
            check_output("model y", 12'(y_salida), 12'(m_y));
        end
    end

    task automatic expect_io(input string name, input int st, input int ct, input int x, input int y);
        check_output({name, " estado"}, 12'(estado_actual), 12'(st));
        check_output({name, " cortando"}, 12'(cortando), 12'(ct));
        check_output({name, " x"}, 12'(x_salida), 12'(x));
        check_output({name, " y"}, 12'(y_salida), 12'(y));
    endtask

    task automatic apply_stimulus(input logic [5:0] mask);
        @(negedge clock);
        ctrl = ctrl | mask;
        @(negedge clock);
        ctrl = ctrl & ~mask;
        repeat (3) @(negedge clock);
    endtask

    task automatic store_point(input int x, input int y);
        @(negedge clock);
        x_sensor = 6'(x);
        y_sensor = 6'(y);
        apply_stimulus(GUA);
    endtask

    initial begin
        ctrl = '0; x_sensor = '0; y_sensor = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        expect_io("reset", 0, 0, 0, 0);
        reset_n = 1'b1;

        apply_stimulus(INI);
        expect_io("record entry", 1, 0, 0, 0);

        for (int k = 1; k <= 14; k++) store_point(k, k);
        apply_stimulus(COR);
        expect_io("cut start", 2, 1, 1, 1);

        repeat (13) apply_stimulus(DAT);
        expect_io("cut point 14", 2, 1, 14, 14);
        apply_stimulus(DAT);
        expect_io("done", 4, 0, 14, 14);

        apply_stimulus(COR);
        expect_io("replay", 2, 1, 1, 1);

        // A held-high level must advance only once.
        @(negedge clock);
        ctrl = ctrl | DAT;
        repeat (4) @(negedge clock);
        ctrl = ctrl & ~DAT;
        repeat (3) @(negedge clock);
        expect_io("held dato", 2, 1, 2, 2);

        apply_stimulus(DAT);
        expect_io("point 3", 2, 1, 3, 3);
        apply_stimulus(PAU);
        expect_io("pause", 3, 0, 3, 3);
        apply_stimulus(DAT);
        expect_io("pause dato", 3, 0, 3, 3);
        apply_stimulus(PAU);
        expect_io("resume", 2, 1, 3, 3);
        apply_stimulus(PAU | DAT);
        expect_io("pause over dato", 3, 0, 3, 3);
        apply_stimulus(PAU);
        expect_io("resume again", 2, 1, 3, 3);

        apply_stimulus(INI);
        expect_io("stop", 0, 0, 0, 0);
        apply_stimulus(INI);
        expect_io("record again", 1, 0, 0, 0);

        for (int k = 1; k <= 17; k++) store_point(k, 40 - k);
        apply_stimulus(COR);
        expect_io("full cut start", 2, 1, 1, 39);
        repeat (15) apply_stimulus(DAT);
        expect_io("full point 16", 2, 1, 16, 24);
        apply_stimulus(DAT);
        expect_io("full done", 4, 0, 16, 24);

        apply_stimulus(COR);
        expect_io("replay full", 2, 1, 1, 39);
        apply_stimulus(DAT);
        expect_io("replay point 2", 2, 1, 2, 38);
        apply_stimulus(CAN | DAT);
        expect_io("cancel", 0, 0, 0, 0);
        apply_stimulus(INI);
        expect_io("record after cancel", 1, 0, 0, 0);
        apply_stimulus(COR);
        expect_io("cut empty", 1, 0, 0, 0);

        store_point(5, 6);
        store_point(7, 8);
        apply_stimulus(COR);
        expect_io("short cut", 2, 1, 5, 6);
        apply_stimulus(DAT);
        expect_io("short point 2", 2, 1, 7, 8);

        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 expect_io("async reset", 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        expect_io("after reset", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
